mem_bus_master: RTL and testbench

- Bus initiator that runs single-word read and write transactions on the shared tri-state sysbus.
- Drives the control signals memory responders (ROM, RAM) consume: load_MAR, MDR_bus, load_MDR, CS, R_NW.
- The sequencer/datapath issues one request at a time through a simple req/ack interface.
- Handles address phase, data phase and bus turnaround so no two agents ever drive sysbus together.

---
 rtl/mem_bus_master.sv | 115 +++++++++++
 tb/tb_mem_bus_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Single-word read/write initiator for the shared tri-state sysbus.
// Moore FSM: bus controls decode from state, ack/rdata are registered.
module mem_bus_master #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic                     clock,
   input  logic                     n_reset,
   input  logic                     req,
   input  logic                     wr,
   input  logic [WORD_W-OP_W-1:0]   addr,
   input  logic [WORD_W-1:0]        wdata,
   output logic [WORD_W-1:0]        rdata,
   output logic                     ack,
   output logic                     busy,
   output logic                     load_MAR,
   output logic                     MDR_bus,
   output logic                     load_MDR,
   output logic                     CS,
   output logic                     R_NW,
   inout  wire  [WORD_W-1:0]        sysbus
);

   localparam int AW = WORD_W - OP_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              drive_en;
   logic [WORD_W-1:0] drive_val;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ack_d     = 1'b0;
      load_MAR  = 1'b0;
      MDR_bus   = 1'b0;
      load_MDR  = 1'b0;
      CS        = 1'b0;
      R_NW      = 1'b1;
      drive_en  = 1'b0;
      drive_val = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               wr_d    = wr;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = ADDR;
            end
         end
         ADDR: begin
            drive_en  = 1'b1;
            drive_val = {{OP_W{1'b0}}, addr_q};
            load_MAR  = 1'b1;
            state_d   = wr_q ? WRITE : READ;
         end
         READ: begin
            // responder owns the bus this cycle
            MDR_bus = 1'b1;
            CS      = 1'b1;
            rdata_d = sysbus;
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         WRITE: begin
            drive_en  = 1'b1;
            drive_val = wdata_q;
            load_MDR  = 1'b1;
            CS        = 1'b1;
            R_NW      = 1'b0;
            ack_d     = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sysbus = drive_en ? drive_val : {WORD_W{1'bz}};
   assign rdata  = rdata_q;
   assign ack    = ack_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a RAM responder model
// and a queue of expected read data checked at each ack.
module tb_mem_bus_master;

   logic       clock = 1'b0;
   logic       n_reset;
   logic       req;
   logic       wr;
   logic [4:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       ack, busy;
   logic       load_MAR, MDR_bus, load_MDR, CS, R_NW;
   wire  [7:0] sysbus;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_ack;
   logic [7:0] zz = 8'hzz;

   logic [7:0] mem [32];
   logic [7:0] ref_mem [32];
   logic [4:0] mar;
   logic [7:0] last_rd;
   logic [7:0] sb_q [$];

   mem_bus_master #(.WORD_W(8), .OP_W(3)) dut (
      .clock    (clock),
      .n_reset  (n_reset),
      .req      (req),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ack      (ack),
      .busy     (busy),
      .load_MAR (load_MAR),
      .MDR_bus  (MDR_bus),
      .load_MDR (load_MDR),
      .CS       (CS),
      .R_NW     (R_NW),
      .sysbus   (sysbus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // responder: MAR capture, MDR write, MDR drive
   always @(posedge clock) begin
      if (load_MAR) mar <= sysbus[4:0];
      if (load_MDR && CS && !R_NW) mem[mar] <= sysbus;
   end
   assign sysbus = (MDR_bus && CS) ? mem[mar] : 8'hzz;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge while IDLE; the next edge accepts
   task automatic start(input logic w, input logic [4:0] a,
                        input logic [7:0] d);
      req   = 1'b1;
      wr    = w;
      addr  = a;
      wdata = d;
      if (w) begin
         ref_mem[a] = d;
         sb_q.push_back(last_rd);
      end else begin
         last_rd = ref_mem[a];
         sb_q.push_back(ref_mem[a]);
      end
   endtask

   // scoreboard and bus-ownership monitor
   always @(negedge clock) begin
      if (n_reset) begin
         check("ctrl_onehot0",
               8'($onehot0({load_MAR, MDR_bus, load_MDR})), 8'd1);
         check("busy_vs_ctrl",
               8'(busy), 8'(|{load_MAR, MDR_bus, load_MDR}));
         if (MDR_bus)
            check("no_contention", 8'(^sysbus === 1'bx), 8'd0);
         if (ack) begin
            if (sb_q.size() == 0) begin
               check("ack_unexpected", 8'(ack), 8'd0);
            end else begin
               check("sb_rdata", rdata, sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      n_reset = 1'b0;
      req     = 1'b0;
      wr      = 1'b0;
      addr    = '0;
      wdata   = '0;
      last_rd = '0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
      mem[1]  = 8'h11;
      mem[2]  = 8'h22;
      mem[3]  = 8'hA5;
      mem[30] = 8'hE0;
      mem[31] = 8'hEE;
      for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

      // reset then idle
      repeat (2) @(negedge clock);
      check("rst_sysbus", sysbus, zz);
      check("rst_ack", 8'(ack), 8'd0);
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_rnw", 8'(R_NW), 8'd1);
      n_reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("idle_sysbus", sysbus, zz);
         check("idle_ack", 8'(ack), 8'd0);
         check("idle_busy", 8'(busy), 8'd0);
         check("idle_rdata", rdata, 8'h00);
         check("idle_rnw", 8'(R_NW), 8'd1);
      end

      // read address 3
      start(1'b0, 5'd3, 8'h00);
      @(negedge clock);
      check("rd_addr_mar", 8'(load_MAR), 8'd1);
      check("rd_addr_bus", sysbus, 8'h03);
      check("rd_addr_cs", 8'(CS), 8'd0);
      req  = 1'b0;
      addr = 5'd9;
      @(negedge clock);
      check("rd_data_mdr", 8'(MDR_bus), 8'd1);
      check("rd_data_cs", 8'(CS), 8'd1);
      check("rd_data_rnw", 8'(R_NW), 8'd1);
      check("rd_data_ack", 8'(ack), 8'd0);
      @(negedge clock);
      check("rd_ack", 8'(ack), 8'd1);
      check("rd_busy", 8'(busy), 8'd0);
      check("rd_rdata", rdata, 8'hA5);

      // write 5C to 20
      start(1'b1, 5'd20, 8'h5C);
      @(negedge clock);
      check("wr_addr_bus", sysbus, 8'h14);
      req   = 1'b0;
      wdata = 8'hFF;
      @(negedge clock);
      check("wr_data_bus", sysbus, 8'h5C);
      check("wr_data_mdr", 8'(load_MDR), 8'd1);
      check("wr_data_rnw", 8'(R_NW), 8'd0);
      check("wr_data_cs", 8'(CS), 8'd1);
      @(negedge clock);
      check("wr_ack", 8'(ack), 8'd1);
      check("wr_rdata_hold", rdata, 8'hA5);

      // read back 20
      start(1'b0, 5'd20, 8'h00);
      @(negedge clock);
      req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rb_ack", 8'(ack), 8'd1);
      check("rb_rdata", rdata, 8'h5C);

      // back-to-back, req held, addr perturbed mid-transaction
      start(1'b0, 5'd1, 8'h00);
      for (int t = 0; t < 3; t++) begin
         @(negedge clock);
         check("b2b_addr_bus", sysbus, 8'(t + 1));
         check("b2b_busy_a", 8'(busy), 8'd1);
         addr = 5'd31 - 5'(t);
         @(negedge clock);
         check("b2b_busy_d", 8'(busy), 8'd1);
         check("b2b_noack", 8'(ack), 8'd0);
         @(negedge clock);
         check("b2b_ack", 8'(ack), 8'd1);
         check("b2b_busy_k", 8'(busy), 8'd0);
         if (t > 0) check("b2b_spacing", 8'(cyc - last_ack), 8'd3);
         last_ack = cyc;
         if (t < 2) start(1'b0, 5'(t + 2), 8'h00);
         else req = 1'b0;
      end
      @(negedge clock);
      check("b2b_end_busy", 8'(busy), 8'd0);
      check("b2b_end_ack", 8'(ack), 8'd0);
      check("b2b_rdata", rdata, 8'hA5);

      // reset during READ
      start(1'b0, 5'd2, 8'h00);
      @(negedge clock);
      req = 1'b0;
      @(negedge clock);
      check("mr_in_read", 8'(MDR_bus), 8'd1);
      n_reset = 1'b0;
      #1;
      sb_q.delete();
      last_rd = 8'h00;
      check("mr_sysbus", sysbus, zz);
      check("mr_ctrl", 8'({load_MAR, MDR_bus, load_MDR, CS}), 8'd0);
      check("mr_rnw", 8'(R_NW), 8'd1);
      check("mr_busy", 8'(busy), 8'd0);
      check("mr_rdata", rdata, 8'h00);
      @(negedge clock);
      check("mr_noack", 8'(ack), 8'd0);
      n_reset = 1'b1;
      @(negedge clock);
      check("mr_noack2", 8'(ack), 8'd0);
      start(1'b0, 5'd3, 8'h00);
      @(negedge clock);
      req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("mr_next_ack", 8'(ack), 8'd1);
      check("mr_next_rdata", rdata, 8'hA5);
      @(negedge clock);
      check("sb_drained", 8'(sb_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
